// File: rtl/hazard_ctrl_pkg.sv
// Shared defines for the hazard controller: opcodes, forwarding-select encodings,
// FSM states and the shadow-pipeline entry used to track in-flight writers.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE      = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE_DMEM = 7'b0000011;
  localparam logic [6:0] OP_I_ARITH     = 7'b0010011;
  localparam logic [6:0] OP_S_TYPE      = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE      = 7'b1100011;
  localparam logic [6:0] OP_JALR        = 7'b1100111;
  localparam logic [6:0] OP_JAL         = 7'b1101111;
  localparam logic [6:0] OP_LUI         = 7'b0110111;
  localparam logic [6:0] OP_AUIPC       = 7'b0010111;

  localparam logic [1:0] FWD_GPR    = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, FLUSH} hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
    logic       is_store;
  } shadow_t;

  function automatic shadow_t mk_entry(logic valid, logic [6:0] op, logic [4:0] rd);
    shadow_t e;
    e.valid    = valid;
    e.rd       = rd;
    e.we       = op inside {OP_R_TYPE, OP_I_ARITH, OP_I_TYPE_DMEM, OP_JALR,
                            OP_JAL, OP_LUI, OP_AUIPC};
    e.is_load  = (op == OP_I_TYPE_DMEM);
    e.is_store = (op == OP_S_TYPE);
    return e;
  endfunction

  function automatic logic src_hit(shadow_t e, logic [4:0] rs, logic use_rs);
    return use_rs && e.valid && e.we && (e.rd != 5'd0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_src_dec.sv
// Extracts rs1/rs2 from the ID instruction and flags which of them the opcode reads.
module hazard_src_dec import hazard_ctrl_pkg::*; (
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic unused_bits;
  assign unused_bits = ^{inst[31:25], inst[14:7]};

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (inst[6:0])
      OP_R_TYPE, OP_S_TYPE, OP_B_TYPE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I_ARITH, OP_I_TYPE_DMEM, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait, forwarding.
// HAZARD_FORWARDING_EN defined: EX/MEM forwarding; undefined: stall until no RAW match remains.
module hazard_ctrl import hazard_ctrl_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_taken,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_if,
  output logic        stall_mem,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel
);

  localparam int SH_EX  = 0;
  localparam int SH_MEM = 1;

  logic [4:0] rs1, rs2;
  logic       use_rs1, use_rs2;

  hazard_src_dec u_src_dec (
    .inst    (id_inst),
    .rs1     (rs1),
    .rs2     (rs2),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  shadow_t [2:0] shd;
  hz_state_e     state_q, state_d;
  logic          flush_pend_q, flush_pend_d;
  logic [1:0]    fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [2:0]    hit_a, hit_b;
  logic          ld_hz, mem_busy, taken;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      hit_a[k] = id_valid & src_hit(shd[k], rs1, use_rs1);
      hit_b[k] = id_valid & src_hit(shd[k], rs2, use_rs2);
    end
  end

`ifdef HAZARD_FORWARDING_EN
  assign ld_hz   = (hit_a[SH_EX] | hit_b[SH_EX]) & shd[SH_EX].is_load;
  assign fwd_a_d = hit_a[SH_EX] ? FWD_EX_MEM : hit_a[SH_MEM] ? FWD_MEM_WB : FWD_GPR;
  assign fwd_b_d = hit_b[SH_EX] ? FWD_EX_MEM : hit_b[SH_MEM] ? FWD_MEM_WB : FWD_GPR;
`else
  // No bypass and no GPR write-through: any in-flight writer blocks ID.
  assign ld_hz   = |{hit_a, hit_b};
  assign fwd_a_d = FWD_GPR;
  assign fwd_b_d = FWD_GPR;
`endif

  logic unused_bits;
  assign unused_bits = ^{shd, hit_a, hit_b};

  assign mem_busy = shd[SH_MEM].valid & (shd[SH_MEM].is_load | shd[SH_MEM].is_store) & ~mem_ready;
  // The slot behind a flushed branch is a bubble; a taken flag there is stale.
  assign taken    = ex_taken & (state_q != FLUSH);

  always_comb begin
    state_d      = RUN;
    flush_pend_d = 1'b0;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    flush_if     = 1'b0;
    stall_mem    = 1'b0;
    if (!rst_n)                      state_d = RUN;
    else if (mem_busy) begin
      state_d      = MEM_WAIT;
      flush_pend_d = taken | flush_pend_q;
    end
    else if (taken | flush_pend_q)   state_d = FLUSH;
    else if (ld_hz)                  state_d = LD_STALL;
    case (state_d)
      LD_STALL: begin stall_if = 1'b1; stall_id = 1'b1; bubble_ex = 1'b1; end
      MEM_WAIT: begin stall_if = 1'b1; stall_id = 1'b1; stall_mem = 1'b1; end
      FLUSH:    begin flush_if = 1'b1; bubble_ex = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      shd          <= '0;
      fwd_a_q      <= FWD_GPR;
      fwd_b_q      <= FWD_GPR;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (!stall_mem) begin
        shd[2]      <= shd[1];
        shd[1]      <= shd[0];
        shd[SH_EX]  <= bubble_ex ? '0 : mk_entry(id_valid, id_inst[6:0], id_inst[11:7]);
        fwd_a_q     <= bubble_ex ? FWD_GPR : fwd_a_d;
        fwd_b_q     <= bubble_ex ? FWD_GPR : fwd_b_d;
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a register-number based reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] id_inst = 32'h13;
  logic        id_valid = 1'b0, ex_taken = 1'b0, mem_ready = 1'b1;
  logic        stall_if, stall_id, bubble_ex, flush_if, stall_mem;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_taken(ex_taken), .mem_ready(mem_ready), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .stall_mem(stall_mem), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] ADD3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] SUB4  = 32'h40318233; // sub  x4,x3,x3
  localparam logic [31:0] BEQ   = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] LW7   = 32'h0000A383; // lw   x7,0(x1)
  localparam logic [31:0] ADD8  = 32'h00738433; // add  x8,x7,x7
  localparam logic [31:0] ADDI0 = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADD1  = 32'h000000B3; // add  x1,x0,x0
  localparam logic [31:0] NOP   = 32'h00000013;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Register read as source n (1/2), 0 when the opcode does not read it.
  function automatic int src(input logic [31:0] i, input int n);
    logic [6:0] op;
    bit two, one;
    op  = i[6:0];
    two = op inside {7'h33, 7'h23, 7'h63};
    one = two || (op inside {7'h13, 7'h03, 7'h67});
    if (n == 1) return one ? int'(i[19:15]) : 0;
    return two ? int'(i[24:20]) : 0;
  endfunction

  // Register written, 0 when none (x0 writes count as none).
  function automatic int dst(input logic [31:0] i);
    if (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6f, 7'h37, 7'h17}) return int'(i[11:7]);
    return 0;
  endfunction

  // Model: per in-flight stage (0=EX,1=MEM,2=WB) the register it writes, load and memory flags.
  int         wr[3];
  bit         ld[3], mm[3];
  bit         pend, prev_fl;
  logic [1:0] efa, efb;

  function automatic logic [1:0] fsel(input int r);
    if (!FWD || r == 0) return 2'b00;
    if (wr[0] == r) return 2'b01;
    if (wr[1] == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin wr[k] = 0; ld[k] = 0; mm[k] = 0; end
    pend = 0; prev_fl = 0; efa = 2'b00; efb = 2'b00;
  endtask

  initial model_clear();

  always begin : compare
    logic [8:0] exp_v, act_v;
    bit tk, mw, fl, hz, ls;
    @(negedge clk);
    tk = 0; mw = 0; fl = 0; hz = 0; ls = 0;
    if (!rst_n) begin
      model_clear();
      exp_v = '0;
    end else begin
      tk = ex_taken && !prev_fl;
      mw = mm[1] && !mem_ready;
      fl = !mw && (tk || pend);
      if (id_valid)
        for (int k = 0; k < 3; k++)
          if (wr[k] != 0 && (src(id_inst, 1) == wr[k] || src(id_inst, 2) == wr[k]) &&
              (!FWD || (k == 0 && ld[0])))
            hz = 1;
      ls = !mw && !fl && hz;
      exp_v = {ls | mw, ls | mw, ls | fl, fl, mw, efa, efb};
    end
    act_v = {stall_if, stall_id, bubble_ex, flush_if, stall_mem, fwd_a_sel, fwd_b_sel};
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model t=%0t outs(sif,sid,bub,fl,smem,fa,fb) got %b expected %b",
               $time, act_v, exp_v);
    end
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      if (!mw) begin
        wr[2] = wr[1]; ld[2] = ld[1]; mm[2] = mm[1];
        wr[1] = wr[0]; ld[1] = ld[0]; mm[1] = mm[0];
        if (id_valid && !ls && !fl) begin
          wr[0] = dst(id_inst);
          ld[0] = (id_inst[6:0] == 7'h03);
          mm[0] = (id_inst[6:0] inside {7'h03, 7'h23});
          efa   = fsel(src(id_inst, 1));
          efb   = fsel(src(id_inst, 2));
        end else begin
          wr[0] = 0; ld[0] = 0; mm[0] = 0; efa = 2'b00; efb = 2'b00;
        end
      end
      pend    = mw && (tk || pend);
      prev_fl = fl;
    end
  end

  task automatic cyc(input logic [31:0] i, input logic v, input logic tk, input logic rdy);
    @(posedge clk); #1;
    id_inst = i; id_valid = v; ex_taken = tk; mem_ready = rdy;
    @(negedge clk);
  endtask

  // Present an instruction until ID accepts it; returns the number of stalled cycles.
  task automatic issue(input logic [31:0] i, output int stalls);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(i, 1'b1, 1'b0, 1'b1);
      if (!stall_id) break;
      stalls++;
    end
  endtask

  task automatic drain();
    repeat (3) cyc(NOP, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n, nsm;
    // Outputs must stay low under reset whatever the inputs do.
    id_inst = LW5; id_valid = 1'b1; ex_taken = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_outs", int'({stall_if, stall_id, bubble_ex, flush_if, stall_mem, fwd_a_sel, fwd_b_sel}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; id_valid = 1'b0; ex_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_run", int'({stall_if, stall_mem, flush_if}), 0);

    // Load-use: lw x5 then add x6,x5,x2
    issue(LW5, n);  chk("s1_lw_stalls", n, 0);
    cyc(ADD6, 1'b1, 1'b0, 1'b1);
    chk("s1_ld_use_stall_bubble", int'({stall_if, bubble_ex}), 3);
    issue(ADD6, n); chk("s1_add_extra_stalls", n, FWD ? 0 : 2);
    cyc(NOP, 1'b0, 1'b0, 1'b1);
    chk("s1_fwd_a", int'(fwd_a_sel), FWD ? 2 : 0);
    chk("s1_fwd_b", int'(fwd_b_sel), 0);
    drain();

    // ALU back-to-back: add x3 then sub x4,x3,x3
    issue(ADD3, n); chk("s2_add_stalls", n, 0);
    issue(SUB4, n); chk("s2_sub_stalls", n, FWD ? 0 : 3);
    cyc(NOP, 1'b0, 1'b0, 1'b1);
    chk("s2_fwd_a", int'(fwd_a_sel), FWD ? 1 : 0);
    chk("s2_fwd_b", int'(fwd_b_sel), FWD ? 1 : 0);
    drain();

    // rd = x0 never matches
    issue(ADDI0, n); chk("s5_addi_stalls", n, 0);
    issue(ADD1, n);  chk("s5_add_x0_stalls", n, 0);
    cyc(NOP, 1'b0, 1'b0, 1'b1);
    chk("s5_fwd", int'({fwd_a_sel, fwd_b_sel}), 0);
    drain();

    // Taken branch flushes; the killed lw x7 must not reach EX.
    cyc(BEQ, 1'b1, 1'b0, 1'b1);
    cyc(LW7, 1'b1, 1'b1, 1'b1);
    chk("s3_flush", int'({flush_if, bubble_ex, stall_if}), 6);
    cyc(ADD8, 1'b1, 1'b0, 1'b1);
    chk("s3_after_flush", int'({flush_if, bubble_ex, stall_if}), 0);
    drain();

    // Memory wait of 3 cycles with a taken branch arriving in the second.
    cyc(LW5, 1'b1, 1'b0, 1'b1);
    cyc(NOP, 1'b1, 1'b0, 1'b1);
    nsm = 0;
    cyc(NOP, 1'b1, 1'b0, 1'b0); nsm += int'(stall_mem);
    chk("s4_wait_no_bubble", int'({stall_if, stall_id, bubble_ex}), 6);
    cyc(NOP, 1'b1, 1'b1, 1'b0); nsm += int'(stall_mem);
    chk("s4_flush_deferred", int'(flush_if), 0);
    cyc(NOP, 1'b1, 1'b0, 1'b0); nsm += int'(stall_mem);
    cyc(NOP, 1'b1, 1'b0, 1'b1); nsm += int'(stall_mem);
    chk("s4_stall_mem_cycles", nsm, 3);
    chk("s4_exit_flush", int'({flush_if, bubble_ex, stall_if}), 6);
    cyc(NOP, 1'b1, 1'b0, 1'b1);
    chk("s4_flush_once", int'(flush_if), 0);
    drain();

    // Reset during a memory wait with a pending flush aborts both.
    cyc(LW5, 1'b1, 1'b0, 1'b1);
    cyc(NOP, 1'b1, 1'b0, 1'b1);
    cyc(NOP, 1'b1, 1'b1, 1'b0);
    chk("r_mem_wait", int'(stall_mem), 1);
    @(posedge clk); #1;
    rst_n = 1'b0; ex_taken = 1'b0;
    @(negedge clk);
    chk("r_outs_zero", int'({stall_if, stall_id, bubble_ex, flush_if, stall_mem, fwd_a_sel, fwd_b_sel}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("r_release_run", int'({stall_if, stall_mem, flush_if, bubble_ex}), 0);
    cyc(NOP, 1'b1, 1'b0, 1'b1);
    chk("r_no_late_flush", int'(flush_if), 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
